icache_line_ctrl: RTL and testbench
===================================

Name: icache_line_ctrl

Overview:
- Single-line instruction cache controller that sequences one dpram_32x32 instance: 32 words = one 128-byte line, tag = addr[31:7], word offset = addr[6:2].
- Serves CPU fetches on a hit with 1-cycle latency.
- On a miss or an invalid line, issues a 32-beat burst read to the memory side, writes each beat into the RAM, then returns the requested word.
- Sits between the fetch stage and the memory bus arbiter.

Parameters:
- LINE_WORDS, 32, words per line; fixed by the RAM depth, not overridable.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored
- cpu_rdreq  in  1  fetch request; accepted when cpu_ready=1
- cpu_ready  out  1  controller can accept a request this cycle
- cpu_rddata  out  32  fetched word
- cpu_rdvalid  out  1  one-cycle strobe; cpu_rddata valid
- invalidate  in  1  drop the cached line
- mem_addr  out  32  burst base address {tag,7'b0}
- mem_rdreq  out  1  burst request; held until mem_ack
- mem_ack  in  1  burst accepted
- mem_rddata  in  32  burst beat data
- mem_rdvalid  in  1  beat strobe; beats arrive in order, word 0 first

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, valid=0, tag=0, word counter=0.
  - cpu_ready=1, cpu_rdvalid=0, mem_rdreq=0, mem_addr=0, RAM we=0.
  - Reset mid-fill abandons the burst: mem_rdreq drops, and any mem_rdvalid seen in IDLE is ignored.
- States: IDLE, HIT_RD, REQ, FILL, MISS_RD.
- cpu_ready=1 only in IDLE.
- IDLE, cpu_rdreq=1:
  - The controller latches offset=cpu_addr[6:2] and req_tag=cpu_addr[31:7].
  - On a hit (valid && tag==cpu_addr[31:7]): raddr=cpu_addr[6:2] is driven combinationally, we=0, next state HIT_RD.
  - Otherwise: next state REQ.
- HIT_RD: cpu_rdvalid=1, cpu_rddata=RAM dataout, returns to IDLE. Hit latency is request cycle N → cpu_rdvalid in N+1. No back-to-back acceptance: throughput is 1 fetch per 2 cycles.
- REQ:
  - mem_rdreq=1, mem_addr={req_tag,7'b0}.
  - On mem_ack, mem_rdreq drops next cycle, counter=0, next state FILL.
  - mem_ack and mem_rdvalid in the same cycle is legal; that beat counts as word 0.
- FILL:
  - Each mem_rdvalid drives we=1, waddr=counter, datain=mem_rddata; counter then increments.
  - No RAM reads are issued while we=1, because the RAM suppresses reads during writes.
  - The beat with counter==31 sets tag=req_tag and valid=1 (subject to pending invalidate), and the next state is MISS_RD.
  - The counter is 5 bits, wraps to 0 after 31, and returns to 0 at fill end.
- MISS_RD: raddr=offset, we=0, next state HIT_RD, which delivers the word. Miss latency is N+1 (REQ) + ack wait + 32 beats + 2 cycles.
- invalidate:
  - In IDLE: valid=0 next cycle. If it coincides with cpu_rdreq, invalidate takes priority and the request is treated as a miss.
  - In REQ, FILL or MISS_RD: a sticky inv_pend flag is set. The fill still completes and the requested word is still returned, but valid stays 0. inv_pend clears on return to IDLE.
  - In HIT_RD: valid=0 next cycle; the word being returned is still delivered.
- cpu_rdreq outside IDLE is ignored; the requester holds it until cpu_ready=1.
- Gaps between mem_rdvalid beats are arbitrary; the counter only advances on beats.

Decomposition:
- Shared package icache_pkg:
  - state encoding constants (IDLE=0, HIT_RD=1, REQ=2, FILL=3, MISS_RD=4, 3 bits).
  - TAG_LSB=7, OFS_LSB=2, OFS_W=5.
- One sub-module: dpram_32x32 (u_ram). It is the sole storage, driven by raddr/waddr/datain/we from this controller.
- Tag, valid, counter and the FSM live in icache_line_ctrl.

Test Plan:
- Cold miss:
  - Stimulus: after reset, cpu_rdreq with cpu_addr=0x0000_1008; memory acks after 3 cycles and returns beats 0xA000_0000+i.
  - Required response: mem_addr=0x0000_1000, mem_rdreq held until ack, exactly 32 RAM writes; cpu_rdvalid with cpu_rddata=0xA000_0002.
- Hit:
  - Stimulus: after the cold fill, request cpu_addr=0x0000_107C.
  - Required response: cpu_rdvalid exactly 1 cycle later, data 0xA000_001F, mem_rdreq stays 0.
- Tag mismatch:
  - Stimulus: request 0x0000_2004.
  - Required response: new burst at mem_addr=0x0000_2000, returned word = beat 1; a subsequent 0x0000_1008 misses again.
- Stalled beats:
  - Stimulus: mem_rdvalid with random gaps of 0–5 cycles, plus ack and first beat in the same cycle.
  - Required response: all 32 words land at the correct offsets (read back via hits 0..31).
- Invalidate during fill:
  - Stimulus: pulse invalidate at beat 10.
  - Required response: the requested word is still returned; the next request to the same line re-fetches (mem_rdreq=1).
- Reset mid-fill:
  - Stimulus: reset_n=0 at beat 20, then the request is reissued.
  - Required response: cpu_ready=1 and mem_rdreq=0 after the reset edge; the reissued request misses and performs a full 32-beat fill.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared constants for the single-line instruction cache controller:
//   - address split (tag = addr[31:7], word offset = addr[6:2])
//   - line geometry (32 words of 32 bits, matching dpram_32x32)
//   - FSM state encoding (3-bit localparams)
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 32;
    localparam int TAG_LSB    = 7;
    localparam int OFS_LSB    = 2;
    localparam int OFS_W      = 5;
    localparam int TAG_W      = ADDR_W - TAG_LSB;

    // Value of the beat counter while the final word of the line is written.
    localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(LINE_WORDS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HIT_RD  = 3'd1;
    localparam logic [2:0] ST_REQ     = 3'd2;
    localparam logic [2:0] ST_FILL    = 3'd3;
    localparam logic [2:0] ST_MISS_RD = 3'd4;

endpackage

// File: rtl/icache_line_ctrl_dpram.sv
// -----------------------------------------------------------------------------
// dpram_32x32
// 32-word x 32-bit simple dual-port RAM holding the single cache line.
// One write port and one registered read port sharing clk. A read is only
// performed in cycles without a write; o_dataout holds its last value when
// a write occurs.
// Ports:
//   clk        system clock
//   i_we       write enable
//   i_waddr    write word address
//   i_datain   write data
//   i_raddr    read word address (sampled when i_we=0)
//   o_dataout  registered read data, valid the cycle after the read
// -----------------------------------------------------------------------------
module dpram_32x32
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [OFS_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_datain,
    input  logic [OFS_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_dataout
);

    logic [DATA_W-1:0] r_mem [LINE_WORDS];

    // NOTE: the array and read register have no reset; contents are
    // meaningless until the controller marks the line valid, and a reset
    // term would stop the array from mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_datain;
        end else begin
            o_dataout <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/icache_line_ctrl.sv
// -----------------------------------------------------------------------------
// icache_line_ctrl
// Single-line instruction cache controller. Serves fetches that hit the
// cached 128-byte line with one cycle of latency; otherwise issues a 32-beat
// burst read, writes every beat into dpram_32x32 and then returns the
// requested word.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cpu_addr/cpu_rdreq    fetch byte address and request (taken when cpu_ready)
//   cpu_ready             controller is idle and accepts a request
//   cpu_rddata/rdvalid    fetched word and its one-cycle strobe
//   invalidate            drop the cached line
//   mem_addr/mem_rdreq    burst base address and request (held until mem_ack)
//   mem_ack               burst accepted
//   mem_rddata/rdvalid    burst beats, word 0 first, arbitrary gaps
// -----------------------------------------------------------------------------
module icache_line_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rdreq,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rddata,
    output logic              cpu_rdvalid,
    input  logic              invalidate,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rdreq,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rddata,
    input  logic              mem_rdvalid
);

    logic [2:0]        r_state;
    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [TAG_W-1:0]  r_req_tag;
    logic [OFS_W-1:0]  r_offset;
    logic [OFS_W-1:0]  r_cnt;
    logic              r_inv_pend;

    logic [TAG_W-1:0]  w_cpu_tag;
    logic [OFS_W-1:0]  w_cpu_ofs;
    logic              w_hit;
    logic              w_beat;
    logic [OFS_W-1:0]  w_raddr;
    logic [DATA_W-1:0] w_ram_q;
    logic              w_unused;

    assign w_cpu_tag = cpu_addr[ADDR_W-1:TAG_LSB];
    assign w_cpu_ofs = cpu_addr[TAG_LSB-1:OFS_LSB];
    assign w_unused  = &{1'b0, cpu_addr[OFS_LSB-1:0]};

    // A coincident invalidate wins over the lookup, forcing a miss.
    assign w_hit = r_valid && (r_tag == w_cpu_tag) && !invalidate;

    // Beat 0 may arrive in the same cycle as mem_ack, while still in REQ.
    assign w_beat = mem_rdvalid &&
                    ((r_state == ST_FILL) || ((r_state == ST_REQ) && mem_ack));

    // In IDLE the read address comes straight from the fetch address so the
    // word is ready one cycle later; elsewhere it is the latched offset.
    // NOTE: the default assignment first keeps this block from inferring a latch.
    always_comb begin
        w_raddr = r_offset;
        if (r_state == ST_IDLE) begin
            w_raddr = w_cpu_ofs;
        end
    end

    dpram_32x32 u_ram (
        .clk       (clk),
        .i_we      (w_beat),
        .i_waddr   (r_cnt),
        .i_datain  (mem_rddata),
        .i_raddr   (w_raddr),
        .o_dataout (w_ram_q)
    );

    assign cpu_ready   = (r_state == ST_IDLE);
    assign cpu_rdvalid = (r_state == ST_HIT_RD);
    assign cpu_rddata  = w_ram_q;
    assign mem_rdreq   = (r_state == ST_REQ);
    assign mem_addr    = {r_req_tag, {TAG_LSB{1'b0}}};

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_tag      <= '0;
            r_req_tag  <= '0;
            r_offset   <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (invalidate) begin
                        r_valid <= 1'b0;
                    end
                    if (cpu_rdreq) begin
                        r_offset  <= w_cpu_ofs;
                        r_req_tag <= w_cpu_tag;
                        if (w_hit) begin
                            r_state <= ST_HIT_RD;
                        end else begin
                            // The RAM is about to be overwritten, so the old
                            // line can no longer be trusted.
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_REQ;
                        end
                    end
                end

                ST_HIT_RD: begin
                    if (invalidate) begin
                        r_valid <= 1'b0;
                    end
                    r_inv_pend <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                ST_REQ: begin
                    if (invalidate) begin
                        r_inv_pend <= 1'b0 | 1'b1;
                    end
                    if (mem_ack) begin
                        r_cnt   <= w_beat ? OFS_W'(1) : '0;
                        r_state <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (invalidate) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_rdvalid) begin
                        // Wraps to 0 after the last word, ready for next fill.
                        r_cnt <= r_cnt + OFS_W'(1);
                        if (r_cnt == LAST_WORD) begin
                            r_tag   <= r_req_tag;
                            r_valid <= !(r_inv_pend || invalidate);
                            r_state <= ST_MISS_RD;
                        end
                    end
                end

                ST_MISS_RD: begin
                    if (invalidate) begin
                        r_inv_pend <= 1'b1;
                        r_valid    <= 1'b0;
                    end
                    r_state <= ST_HIT_RD;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_line_ctrl
// Directed and randomized fetch sequences against icache_line_ctrl. The bench
// plays both the CPU and the memory bus, and keeps a reference model of the
// cached line (valid flag, tag, 32 data words) to predict hit/miss, burst
// address and returned data.
// -----------------------------------------------------------------------------
module tb_icache_line_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_addr;
    logic        cpu_rdreq;
    logic        cpu_ready;
    logic [31:0] cpu_rddata;
    logic        cpu_rdvalid;
    logic        invalidate;
    logic [31:0] mem_addr;
    logic        mem_rdreq;
    logic        mem_ack;
    logic [31:0] mem_rddata;
    logic        mem_rdvalid;

    always #5 clk = ~clk;

    icache_line_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_rdreq   (cpu_rdreq),
        .cpu_ready   (cpu_ready),
        .cpu_rddata  (cpu_rddata),
        .cpu_rdvalid (cpu_rdvalid),
        .invalidate  (invalidate),
        .mem_addr    (mem_addr),
        .mem_rdreq   (mem_rdreq),
        .mem_ack     (mem_ack),
        .mem_rddata  (mem_rddata),
        .mem_rdvalid (mem_rdvalid)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int we_count;

    // Reference model of the cached line.
    bit          m_valid;
    logic [24:0] m_tag;
    logic [31:0] m_line [32];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Inputs are changed on the falling edge; RAM write strobes are counted
    // just before the rising edge that would perform the write.
    task automatic tick();
        #4;
        if (dut.u_ram.i_we === 1'b1) we_count++;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] addr, input int ack_dly, input int max_gap,
                         input bit ack_beat0, input bit inv_req, input int inv_beat,
                         input int rst_beat, input bit inv_hitrd, input logic [31:0] base);
        bit   exp_hit;
        bit   inv_seen;
        bit   aborted;
        int   ofs;
        int   beat;
        int   gap;
        int   lat;
        int   writes0;
        ofs = int'(addr[6:2]);
        inv_seen = 1'b0;
        aborted  = 1'b0;
        check("ready_before_req", cpu_ready, 1);
        exp_hit   = m_valid && (m_tag == addr[31:7]) && !inv_req;
        cpu_addr  = addr;
        cpu_rdreq = 1'b1;
        invalidate = inv_req;
        we_count  = 0;
        tick();
        cpu_rdreq  = 1'b0;
        invalidate = 1'b0;
        cpu_addr   = $urandom;
        if (exp_hit) begin
            check("hit_rdvalid", cpu_rdvalid, 1);
            check("hit_data", cpu_rddata, m_line[ofs]);
            check("hit_no_mem_req", mem_rdreq, 0);
            check("hit_no_writes", we_count, 0);
        end else begin
            m_valid = 1'b0;
            for (int c = 0; c < ack_dly; c++) begin
                check("miss_rdreq_held", mem_rdreq, 1);
                tick();
            end
            check("miss_rdreq_at_ack", mem_rdreq, 1);
            check("miss_mem_addr", mem_addr, addr & 32'hFFFF_FF80);
            mem_ack = 1'b1;
            beat = 0;
            if (ack_beat0) begin
                mem_rdvalid = 1'b1;
                mem_rddata  = base;
                m_line[0]   = base;
                beat = 1;
            end
            tick();
            mem_ack     = 1'b0;
            mem_rdvalid = 1'b0;
            check("rdreq_drops_after_ack", mem_rdreq, 0);
            while (beat < 32) begin
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                for (int g = 0; g < gap; g++) begin
                    mem_rddata = $urandom;
                    tick();
                end
                if (beat == rst_beat) begin
                    reset_n = 1'b0;
                    tick();
                    check("rst_cpu_ready", cpu_ready, 1);
                    check("rst_mem_rdreq", mem_rdreq, 0);
                    reset_n     = 1'b1;
                    mem_rdvalid = 1'b1;
                    mem_rddata  = $urandom;
                    writes0     = we_count;
                    tick();
                    mem_rdvalid = 1'b0;
                    check("idle_beat_ignored", we_count - writes0, 0);
                    check("rst_idle_mem_rdreq", mem_rdreq, 0);
                    m_valid = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                mem_rdvalid  = 1'b1;
                mem_rddata   = base + beat;
                m_line[beat] = base + beat;
                if (beat == inv_beat) begin
                    invalidate = 1'b1;
                    inv_seen   = 1'b1;
                end
                tick();
                mem_rdvalid = 1'b0;
                invalidate  = 1'b0;
                beat++;
            end
            if (!aborted) begin
                // After the last beat's cycle: one MISS_RD cycle, then the word.
                lat = 0;
                while (cpu_rdvalid !== 1'b1 && lat < 8) begin
                    tick();
                    lat++;
                end
                check("miss_latency", lat, 1);
                check("fill_write_count", we_count, 32);
                check("miss_data", cpu_rddata, base + ofs);
                m_tag   = addr[31:7];
                m_valid = !inv_seen;
            end
        end
        if (!aborted) begin
            if (inv_hitrd) begin
                invalidate = 1'b1;
                m_valid    = 1'b0;
            end
            tick();
            invalidate = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] line_base;
        reset_n     = 1'b0;
        cpu_addr    = '0;
        cpu_rdreq   = 1'b0;
        invalidate  = 1'b0;
        mem_ack     = 1'b0;
        mem_rddata  = '0;
        mem_rdvalid = 1'b0;
        m_valid     = 1'b0;
        m_tag       = '0;
        we_count    = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_cpu_ready", cpu_ready, 1);
        check("reset_cpu_rdvalid", cpu_rdvalid, 0);
        check("reset_mem_rdreq", mem_rdreq, 0);
        check("reset_mem_addr", mem_addr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Cold miss: ack after 3 cycles, beats 0xA000_0000+i.
        fetch(32'h0000_1008, 3, 0, 0, 0, -1, -1, 0, 32'hA000_0000);
        // Hit on the last word of the line.
        fetch(32'h0000_107C, 0, 0, 0, 0, -1, -1, 0, 32'h0);
        check("hit_last_word_const", m_line[31], 32'hA000_001F);

        // Tag mismatch, then the old line misses again.
        fetch(32'h0000_2004, 1, 0, 0, 0, -1, -1, 0, $urandom);
        fetch(32'h0000_1008, 0, 0, 0, 0, -1, -1, 0, $urandom);

        // Stalled beats with ack and beat 0 together; read every word back.
        fetch(32'h0000_301C, 0, 5, 1, 0, -1, -1, 0, $urandom);
        for (int i = 0; i < 32; i++) begin
            fetch(32'h0000_3000 + 32'(4 * i), 0, 0, 0, 0, -1, -1, 0, 32'h0);
        end

        // Invalidate during the fill: word returned, line re-fetched after.
        fetch(32'h0000_4010, 2, 2, 0, 0, 10, -1, 0, $urandom);
        fetch(32'h0000_4010, 1, 1, 0, 0, -1, -1, 0, $urandom);
        fetch(32'h0000_4014, 0, 0, 0, 0, -1, -1, 0, 32'h0);

        // Reset at beat 20, then the request is reissued and fully filled.
        fetch(32'h0000_5020, 1, 1, 0, 0, -1, 20, 0, $urandom);
        fetch(32'h0000_5020, 1, 1, 0, 0, -1, -1, 0, $urandom);
        fetch(32'h0000_5024, 0, 0, 0, 0, -1, -1, 0, 32'h0);

        // Invalidate with a request forces a miss; invalidate during HIT_RD.
        fetch(32'h0000_5028, 0, 0, 0, 1, -1, -1, 0, $urandom);
        fetch(32'h0000_502C, 0, 0, 0, 0, -1, -1, 1, 32'h0);
        fetch(32'h0000_502C, 0, 1, 1, 0, -1, -1, 0, $urandom);

        // Randomized traffic over three lines.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(2, 0))
                0:       line_base = 32'h0000_1000;
                1:       line_base = 32'h0000_2000;
                default: line_base = 32'h0000_3000;
            endcase
            fetch(line_base + 32'(4 * $urandom_range(31, 0)),
                  int'($urandom_range(2, 0)), 3, 1'($urandom_range(1, 0)),
                  ($urandom_range(7, 0) == 0), -1, -1,
                  ($urandom_range(7, 0) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
